// File: rtl/mmio_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// mmio_rd_if
// One MMIO read channel: an AR request handshake plus an R data handshake.
//   master modport : drives arAddr/arWidth/arValid and rReady,
//                    receives arReady, rData and rValid.
//   slave  modport : the opposite direction.
// Parameters: ADDR_W (address width), DATA_W (read data width).
// arWidth is the access size in bytes (1/2/4) and is always 32 bits wide.
// ---------------------------------------------------------------------------
interface mmio_rd_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] arAddr;
    logic [31:0]       arWidth;
    logic              arValid;
    logic              arReady;
    logic [DATA_W-1:0] rData;
    logic              rValid;
    logic              rReady;

    modport master (
        output arAddr, arWidth, arValid, rReady,
        input  arReady, rData, rValid
    );

    modport slave (
        input  arAddr, arWidth, arValid, rReady,
        output arReady, rData, rValid
    );
endinterface

// File: rtl/mmio_rd_arbiter.sv
// ---------------------------------------------------------------------------
// mmio_rd_arbiter
// Shares the single MMIO read channel between instruction fetch (master 0)
// and load/store (master 1). One read is in flight at a time:
//   IDLE : pick a winner, accept it combinationally, latch its addr/width
//   ADDR : present the latched request to the slave until s.arReady
//   DATA : pass the slave R beat straight through to the granted master
//
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low
//   m0, m1   : mmio_rd_if.slave  - requesting masters
//   s        : mmio_rd_if.master - shared downstream slave channel
//   busy     : high whenever the arbiter is not idle
//   grant_id : index of the current or most recently granted master
//
// Configuration macro:
//   MMIO_ARB_RR_EN defined   : round-robin on contention (the master not
//                              granted last wins; master 0 wins the first
//                              tie after reset)
//   MMIO_ARB_RR_EN undefined : fixed priority, master 1 wins contention
// ---------------------------------------------------------------------------
module mmio_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      reset,
    mmio_rd_if.slave  m0,
    mmio_rd_if.slave  m1,
    mmio_rd_if.master s,
    output logic      busy,
    output logic      grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       width_q;
    logic              grant_q;
    logic              ar_valid_q;
    logic              busy_q;
`ifdef MMIO_ARB_RR_EN
    logic              last_q;   // master granted by the last completed read
`endif

    logic              win_d;    // master that would be accepted this cycle
    logic              accept;
    logic              in_data;
    logic              r_done;

    // -----------------------------------------------------------------------
    // Arbitration decision (combinational; only consumed in IDLE)
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        win_d = 1'b0;
        if (m0.arValid && m1.arValid) begin
`ifdef MMIO_ARB_RR_EN
            win_d = ~last_q;
`else
            win_d = 1'b1;
`endif
        end else begin
            win_d = m1.arValid;
        end
    end

    // Gating with reset keeps arReady low while reset is held even though
    // the acceptance path is combinational from arValid.
    assign accept  = reset && (state_q == IDLE) && (m0.arValid || m1.arValid);
    assign in_data = (state_q == DATA);
    assign r_done  = in_data && s.rValid && s.rReady;

    // -----------------------------------------------------------------------
    // Combinational handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        m0.arReady = accept && !win_d;
        m1.arReady = accept &&  win_d;

        // R is a zero-latency pass-through; the non-granted side sees zeros.
        s.rReady   = in_data && (grant_q ? m1.rReady : m0.rReady);
        m0.rValid  = in_data && !grant_q && s.rValid;
        m1.rValid  = in_data &&  grant_q && s.rValid;
        m0.rData   = (in_data && !grant_q) ? s.rData : '0;
        m1.rData   = (in_data &&  grant_q) ? s.rData : '0;

        s.arAddr   = addr_q;
        s.arWidth  = width_q;
        s.arValid  = ar_valid_q;
        busy       = busy_q;
        grant_id   = grant_q;
    end

    // -----------------------------------------------------------------------
    // FSM with registered AR-side outputs
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            width_q    <= '0;
            grant_q    <= 1'b0;
            ar_valid_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef MMIO_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= win_d ? m1.arAddr  : m0.arAddr;
                        width_q    <= win_d ? m1.arWidth : m0.arWidth;
                        grant_q    <= win_d;
                        ar_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ADDR;
                    end
                end
                ADDR: begin
                    if (s.arReady) begin
                        ar_valid_q <= 1'b0;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (r_done) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
`ifdef MMIO_ARB_RR_EN
                        last_q  <= grant_q;
`endif
                    end
                end
                default: begin
                    ar_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule
